// File: rtl/seg7_scan_decoder.sv
// Receive-side decoder for an active-low multiplexed 7-segment bus (an/seg/dp).
// Waits for each digit to settle, decodes it to BCD and hands whole frames downstream.
module seg7_scan_decoder #(
   parameter int STABLE_CYCLES = 4,
   parameter int FRAME_TIMEOUT = 1000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  an,
   input  logic [6:0]  seg,
   input  logic        dp,
   output logic [15:0] digits,
   output logic [3:0]  dp_out,
   output logic [3:0]  digit_ok,
   output logic [3:0]  digit_seen,
   output logic        frame_valid,
   input  logic        frame_ready,
   output logic        overrun
);
   // state       | meaning
   // ST_WAIT     | no single active digit on the bus
   // ST_COUNT    | same {an,seg,dp} repeating, stability count running
   // ST_CAPTURED | digit already taken during this activation episode
   typedef enum logic [1:0] {ST_WAIT, ST_COUNT, ST_CAPTURED} state_t;

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam int TW = $clog2(FRAME_TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
   localparam logic [TW-1:0] TMR_ONE  = TW'(1);
   localparam logic [TW-1:0] TMR_MAX  = TW'(FRAME_TIMEOUT);

   logic [11:0] sync_a, sync_b, prev;
   logic [6:0]  s_seg, pat;
   logic [3:0]  s_an;
   logic        s_dp;
   logic        single;
   logic [1:0]  idx;
   logic [3:0]  dec_val;
   logic        dec_ok;
   state_t      state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic        capture, timeout, wrap, close;
   logic [15:0] wk_val;
   logic [3:0]  wk_ok, wk_dp, wk_seen;
   logic [1:0]  last_idx;
   logic [TW-1:0] timer;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_a <= '0;
         sync_b <= '0;
      end else begin
         sync_a <= {an, seg, dp};
         sync_b <= sync_a;
      end
   end

   assign s_an  = sync_b[11:8];
   assign s_seg = sync_b[7:1];
   assign s_dp  = sync_b[0];
   assign pat   = ~s_seg;

   always_comb begin
      single = 1'b1;
      idx    = 2'd0;
      case (s_an)
         4'b1110: idx = 2'd0;
         4'b1101: idx = 2'd1;
         4'b1011: idx = 2'd2;
         4'b0111: idx = 2'd3;
         default: single = 1'b0;
      endcase
   end

   always_comb begin
      dec_val = 4'hF;
      dec_ok  = 1'b1;
      case (pat)
         7'b0111111: dec_val = 4'd0;
         7'b0000110: dec_val = 4'd1;
         7'b1011011: dec_val = 4'd2;
         7'b1001111: dec_val = 4'd3;
         7'b1100110: dec_val = 4'd4;
         7'b1101101: dec_val = 4'd5;
         7'b1111101: dec_val = 4'd6;
         7'b0000111: dec_val = 4'd7;
         7'b1111111: dec_val = 4'd8;
         7'b1101111: dec_val = 4'd9;
         default:    dec_ok  = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_WAIT;
         cnt   <= '0;
         prev  <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         prev  <= sync_b;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      capture  = 1'b0;
      if (!single) begin
         state_nx = ST_WAIT;
         cnt_nx   = '0;
      end else if (state == ST_WAIT || sync_b != prev) begin
         state_nx = ST_COUNT;
         cnt_nx   = CNT_ONE;
      end else if (state == ST_COUNT) begin
         if (cnt == CNT_LAST) begin
            capture  = 1'b1;
            state_nx = ST_CAPTURED;
         end
         if (cnt != CNT_MAX) cnt_nx = cnt + CNT_ONE;
      end
      // a timeout re-arms the FSM so a static display keeps producing frames
      if (timeout && !capture && single) begin
         state_nx = ST_COUNT;
         cnt_nx   = CNT_ONE;
      end
   end

   assign timeout = (wk_seen != 4'b0) && (timer == TMR_MAX);
   assign wrap    = capture && (wk_seen != 4'b0) && (idx <= last_idx);
   assign close   = wrap || timeout;

   always_ff @(posedge clk) begin
      if (rst) begin
         wk_val   <= '1;
         wk_ok    <= '0;
         wk_dp    <= '0;
         wk_seen  <= '0;
         last_idx <= '0;
         timer    <= '0;
      end else begin
         if (close) begin
            wk_val  <= '1;
            wk_ok   <= '0;
            wk_dp   <= '0;
            wk_seen <= '0;
         end
         // a capture on a closing edge lands in the freshly cleared set
         if (capture) begin
            wk_val[{idx, 2'b00} +: 4] <= dec_val;
            wk_ok[idx]   <= dec_ok;
            wk_dp[idx]   <= ~s_dp;
            wk_seen[idx] <= 1'b1;
            last_idx     <= idx;
         end
         if (capture && (wk_seen == 4'b0 || close)) timer <= TMR_ONE;
         else if (timeout) timer <= '0;
         else if (wk_seen != 4'b0 && timer != TMR_MAX) timer <= timer + TMR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         digits      <= 16'hFFFF;
         dp_out      <= '0;
         digit_ok    <= '0;
         digit_seen  <= '0;
         frame_valid <= 1'b0;
         overrun     <= 1'b0;
      end else if (close) begin
         digits      <= wk_val;
         dp_out      <= wk_dp;
         digit_ok    <= wk_ok;
         digit_seen  <= wk_seen;
         frame_valid <= 1'b1;
         if (frame_valid && !frame_ready) overrun <= 1'b1;
      end else if (frame_valid && frame_ready) begin
         frame_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: frame-level reference model compared every cycle,
// plus directed scan patterns with hand-computed frame contents.
module tb_seg7_scan_decoder;
   localparam int STABLE = 4;
   localparam int TMO    = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  an = 4'hF;
   logic [6:0]  seg = 7'h7F;
   logic        dp = 1'b1;
   logic        frame_ready = 1'b1;
   logic [15:0] digits;
   logic [3:0]  dp_out, digit_ok, digit_seen;
   logic        frame_valid, overrun;

   seg7_scan_decoder #(.STABLE_CYCLES(STABLE), .FRAME_TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .an(an), .seg(seg), .dp(dp),
      .digits(digits), .dp_out(dp_out), .digit_ok(digit_ok), .digit_seen(digit_seen),
      .frame_valid(frame_valid), .frame_ready(frame_ready), .overrun(overrun)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
   endtask

   function automatic logic [6:0] pat_of(input int v);
      case (v)
         0: return 7'b0111111;
         1: return 7'b0000110;
         2: return 7'b1011011;
         3: return 7'b1001111;
         4: return 7'b1100110;
         5: return 7'b1101101;
         6: return 7'b1111101;
         7: return 7'b0000111;
         8: return 7'b1111111;
         default: return 7'b1101111;
      endcase
   endfunction

   // reference model: raw pin history, run length of identical samples, frame arrays
   logic [11:0] p0, p1, last_samp;
   int run, m_last, t_first, cyc;
   bit taken;
   int mw_val[4];
   bit mw_ok[4], mw_dp[4], mw_seen[4];
   logic [15:0] mo_digits;
   logic [3:0]  mo_dp, mo_ok, mo_seen;
   logic        mo_valid, mo_ovr;

   always @(posedge clk) begin
      logic [11:0] samp;
      logic [6:0]  pat;
      int k, zeros, val;
      bit cap, tmo, wrap, nonempty, okv;
      cyc++;
      if (rst) begin
         p0 = '0; p1 = '0; last_samp = '0; run = 0; taken = 0; m_last = 0;
         for (int i = 0; i < 4; i++) begin
            mw_val[i] = 15; mw_ok[i] = 0; mw_dp[i] = 0; mw_seen[i] = 0;
         end
         mo_digits = 16'hFFFF; mo_dp = '0; mo_ok = '0; mo_seen = '0;
         mo_valid = 1'b0; mo_ovr = 1'b0;
      end else begin
         samp = p1; p1 = p0; p0 = {an, seg, dp};
         zeros = 0; k = 0;
         for (int i = 0; i < 4; i++) if (!samp[8+i]) begin zeros++; k = i; end
         pat = ~samp[7:1]; val = 15; okv = 0;
         for (int v = 0; v < 10; v++) if (pat == pat_of(v)) begin val = v; okv = 1; end
         cap = 0;
         if (zeros != 1) begin
            run = 0; taken = 0;
         end else begin
            if (run > 0 && samp == last_samp) run++;
            else begin run = 1; taken = 0; end
            if (run == STABLE && !taken) begin cap = 1; taken = 1; end
         end
         last_samp = samp;
         nonempty = mw_seen[0] | mw_seen[1] | mw_seen[2] | mw_seen[3];
         tmo  = nonempty && (cyc - t_first == TMO);
         wrap = cap && nonempty && (k <= m_last);
         if (tmo && !cap && zeros == 1) begin run = 1; taken = 0; end
         if (wrap || tmo) begin
            for (int i = 0; i < 4; i++) begin
               mo_digits[4*i +: 4] = 4'(mw_val[i]);
               mo_ok[i] = mw_ok[i]; mo_dp[i] = mw_dp[i]; mo_seen[i] = mw_seen[i];
               mw_val[i] = 15; mw_ok[i] = 0; mw_dp[i] = 0; mw_seen[i] = 0;
            end
            if (mo_valid && !frame_ready) mo_ovr = 1'b1;
            mo_valid = 1'b1;
         end else if (mo_valid && frame_ready) begin
            mo_valid = 1'b0;
         end
         if (cap) begin
            if (!nonempty || wrap || tmo) t_first = cyc;
            mw_val[k] = val; mw_ok[k] = okv; mw_dp[k] = ~samp[0]; mw_seen[k] = 1; m_last = k;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("digits", digits, mo_digits);
         check("dp_out", {12'b0, dp_out}, {12'b0, mo_dp});
         check("digit_ok", {12'b0, digit_ok}, {12'b0, mo_ok});
         check("digit_seen", {12'b0, digit_seen}, {12'b0, mo_seen});
         check("frame_valid", {15'b0, frame_valid}, {15'b0, mo_valid});
         check("overrun", {15'b0, overrun}, {15'b0, mo_ovr});
      end
   end

   task automatic drive(input logic [1:0] d, input logic [6:0] p, input logic dp_n, input int n);
      logic [3:0] a;
      a = 4'hF; a[d] = 1'b0;
      an = a; seg = ~p; dp = dp_n;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_raw(input logic [3:0] a, input logic [6:0] s, input logic dp_n, input int n);
      an = a; seg = s; dp = dp_n;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; an = 4'hF; seg = 7'h7F; dp = 1'b1;
      @(posedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      check("rst_digits", digits, 16'hFFFF);
      check("rst_ok_seen_dp", {4'b0, digit_ok, digit_seen, dp_out}, 16'h0000);
      check("rst_valid_ovr", {14'b0, frame_valid, overrun}, 16'h0000);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic wait_valid(input string name, input int limit);
      int i;
      i = 0;
      while (!frame_valid && i < limit) begin @(negedge clk); i++; end
      check(name, {15'b0, frame_valid}, 16'd1);
   endtask

   task automatic expect_frame(input string name, input logic [15:0] d, input logic [3:0] ok,
                               input logic [3:0] seen, input logic [3:0] dpx);
      check({name, "_digits"}, digits, d);
      check({name, "_ok"}, {12'b0, digit_ok}, {12'b0, ok});
      check({name, "_seen"}, {12'b0, digit_seen}, {12'b0, seen});
      check({name, "_dp"}, {12'b0, dp_out}, {12'b0, dpx});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // static single digit: frames come from timeouts
      do_reset();
      frame_ready = 1'b1;
      an = 4'b1110; seg = ~pat_of(3); dp = 1'b0;
      @(negedge clk);
      wait_valid("static_first_valid", 300);
      expect_frame("static_first", 16'hFFF3, 4'b0001, 4'b0001, 4'b0001);
      @(negedge clk);
      check("static_valid_drop", {15'b0, frame_valid}, 16'd0);
      wait_valid("static_second_valid", 300);
      expect_frame("static_second", 16'hFFF3, 4'b0001, 4'b0001, 4'b0001);
      @(posedge clk); #1;

      // clean scan 1,2,3,4
      do_reset();
      for (int i = 0; i < 4; i++) drive(2'(i), pat_of(i + 1), 1'b1, 8);
      drive(2'd0, pat_of(1), 1'b1, 8);
      @(negedge clk);
      expect_frame("scan", 16'h4321, 4'b1111, 4'b1111, 4'b0000);
      @(posedge clk); #1;

      // short digit 2 and a ghosted pair of anodes
      do_reset();
      drive(2'd0, pat_of(1), 1'b1, 8);
      drive(2'd1, pat_of(2), 1'b1, 8);
      drive(2'd2, pat_of(3), 1'b1, 3);
      drive(2'd3, pat_of(4), 1'b1, 8);
      drive_raw(4'b1100, ~pat_of(8), 1'b1, 10);
      drive(2'd0, pat_of(1), 1'b1, 8);
      @(negedge clk);
      expect_frame("glitch", 16'h4F21, 4'b1011, 4'b1011, 4'b0000);
      @(posedge clk); #1;

      // unrecognised pattern and blank digit
      do_reset();
      drive(2'd0, pat_of(5), 1'b1, 8);
      drive(2'd1, 7'b1110110, 1'b1, 8);
      drive_raw(4'b1011, 7'h7F, 1'b1, 8);
      drive(2'd3, pat_of(9), 1'b0, 8);
      drive(2'd0, pat_of(5), 1'b1, 8);
      @(negedge clk);
      expect_frame("unrec", 16'h9FF5, 4'b1001, 4'b1111, 4'b1000);
      @(posedge clk); #1;

      // backpressure across two closes, then accept, then close coinciding with accept
      do_reset();
      frame_ready = 1'b0;
      for (int i = 0; i < 4; i++) drive(2'(i), pat_of(i + 1), 1'b1, 8);
      for (int i = 0; i < 4; i++) drive(2'(i), pat_of(i + 5), 1'b1, 8);
      drive(2'd0, pat_of(9), 1'b1, 8);
      @(negedge clk);
      expect_frame("bp_second", 16'h8765, 4'b1111, 4'b1111, 4'b0000);
      check("bp_overrun", {15'b0, overrun}, 16'd1);
      check("bp_valid_held", {15'b0, frame_valid}, 16'd1);
      @(posedge clk); #1;
      frame_ready = 1'b1;
      @(posedge clk); #1;
      frame_ready = 1'b0;
      @(negedge clk);
      check("bp_accept_drop", {15'b0, frame_valid}, 16'd0);
      check("bp_overrun_sticky", {15'b0, overrun}, 16'd1);
      @(posedge clk); #1;
      for (int i = 1; i < 4; i++) drive(2'(i), pat_of(i), 1'b1, 8);
      drive(2'd0, pat_of(4), 1'b1, 8);
      @(negedge clk);
      check("bp_third_digits", digits, 16'h3219);
      check("bp_third_valid", {15'b0, frame_valid}, 16'd1);
      @(posedge clk); #1;
      for (int i = 1; i < 4; i++) drive(2'(i), pat_of(i + 4), 1'b1, 8);
      drive(2'd0, pat_of(8), 1'b1, 5);
      frame_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_coincide_valid", {15'b0, frame_valid}, 16'd1);
      check("bp_coincide_digits", digits, 16'h7654);
      @(posedge clk); #1;

      // reset in the middle of a frame holding two captures
      drive(2'd1, pat_of(2), 1'b1, 8);
      do_reset();
      drive(2'd2, pat_of(7), 1'b1, 8);
      drive(2'd3, pat_of(8), 1'b1, 8);
      drive(2'd0, pat_of(1), 1'b1, 8);
      @(negedge clk);
      expect_frame("post_reset", 16'h87FF, 4'b1100, 4'b1100, 4'b0000);
      check("post_reset_ovr", {15'b0, overrun}, 16'd0);

      repeat (4) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
